alu_op_sequencer: RTL

- Sequential front end for the 8-bit arithmetic/logic units: suma, resta, C2, the bitwise OR/AND/XOR units and the bytewise OR/AND/XOR units.
- Accepts one opcode plus two operands per transaction over a valid/ready handshake and registers them.
- Evaluates the selected operation and holds a registered result with flags until the downstream consumer takes it.
- Sits between the operand/instruction source and the result sink in the main design.

---
 rtl/alu_op_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Registered opcode/operand front end for the 8-bit ALU units (suma, resta, C2, bitwise and bytewise logic).
// Define ALU_ACC_EN to add an accumulator that can replace operand A for chained operations.
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_a_sel;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_err;
    logic             w_a_nz;
    logic             w_b_nz;

`ifdef ALU_ACC_EN
    logic [WIDTH-1:0] r_acc;
    assign w_a_sel = in_use_acc ? r_acc : in_a;
`else
    logic w_unused_use_acc;
    assign w_unused_use_acc = in_use_acc;
    assign w_a_sel          = in_a;
`endif

    // Arithmetic runs one bit wider so bit WIDTH is the suma carry / resta borrow.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    assign w_a_nz = |r_a;
    assign w_b_nz = |r_b;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (r_op)
            4'd0: begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
            4'd1: begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
            4'd2: w_res = ~r_a + WIDTH'(1);
            4'd3: w_res = r_a | r_b;
            4'd4: w_res = r_a & r_b;
            4'd5: w_res = r_a ^ r_b;
            4'd6: w_res = {{(WIDTH-1){1'b0}}, w_a_nz | w_b_nz};
            4'd7: w_res = {{(WIDTH-1){1'b0}}, w_a_nz & w_b_nz};
            4'd8: w_res = {{(WIDTH-1){1'b0}}, w_a_nz ^ w_b_nz};
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_EXEC;
            end
            S_EXEC: w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments here so every register updates from pre-edge values.
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= '0;
`ifdef ALU_ACC_EN
            r_acc    <= '0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_op <= in_op;
                    r_a  <= w_a_sel;
                    r_b  <= in_b;
                end
                S_EXEC: begin
                    r_result <= w_res;
                    r_carry  <= w_carry;
                    r_zero   <= (w_res == '0);
                    r_err    <= w_err;
                end
                S_DONE: if (out_ready) begin
                    r_count <= r_count + CNT_W'(1);
`ifdef ALU_ACC_EN
                    r_acc   <= r_result;
`endif
                end
                default: ;
            endcase
        end
    end

    assign out_result = r_result;
    assign out_carry  = r_carry;
    assign out_zero   = r_zero;
    assign out_err    = r_err;
    assign op_count   = r_count;

endmodule
